// File: rtl/frame_build_scheduler.sv
// frame_build_scheduler
//   Builds one display frame per halt. Sprite point lists are copied from the
//   image ROM into the display RAM, and each requester's x/y offset is added
//   to every point. Requesters are served in fixed priority order, index 0
//   first. A terminator word closes the frame, then go is raised until the
//   display pulses halt.
// Ports
//   clk, rst              fast clock; rst is asynchronous and active-low
//   halt / go             display handshake (halt pulse in, frame-ready level out)
//   req_en/adr/x/y        per-requester enable, ROM base and offsets, packed with index 0 at the LSBs
//   rom_adr / rom_data    image ROM read port; the ROM answers in the same cycle
//   ram_adr/data/we       display RAM write port
//   frame_len             number of words in the last frame, terminator included
//   overflow              last frame was truncated at RAM_DEPTH
module frame_build_scheduler #(
    parameter int unsigned NREQ       = 4,
    parameter int unsigned ADR_WIDTH  = 16,
    parameter int unsigned DATAWIDTH  = 18,
    parameter int unsigned OUT_WIDTH  = 8,
    parameter int unsigned RAM_DEPTH  = 1000,
    parameter int unsigned MAX_SPRITE = 256
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      halt,
    output logic                      go,
    input  logic [NREQ-1:0]           req_en,
    input  logic [NREQ*ADR_WIDTH-1:0] req_adr,
    input  logic [NREQ*OUT_WIDTH-1:0] req_x,
    input  logic [NREQ*OUT_WIDTH-1:0] req_y,
    output logic [ADR_WIDTH-1:0]      rom_adr,
    input  logic [DATAWIDTH-1:0]      rom_data,
    output logic [ADR_WIDTH-1:0]      ram_adr,
    output logic [DATAWIDTH-1:0]      ram_data,
    output logic                      ram_we,
    output logic [ADR_WIDTH-1:0]      frame_len,
    output logic                      overflow
);

    localparam int unsigned IDX_W = $clog2(NREQ + 1);
    localparam int unsigned SEL_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned K_W   = (MAX_SPRITE > 1) ? $clog2(MAX_SPRITE) : 1;

    localparam logic [DATAWIDTH-1:0] TERM_WORD = {2'b10, {(DATAWIDTH-2){1'b0}}};

    typedef enum logic [2:0] {
        SNAP  = 3'd0,
        SCAN  = 3'd1,
        FETCH = 3'd2,
        TERM  = 3'd3,
        IDLE  = 3'd4
    } state_t;

    state_t                    state_q, state_d;
    logic [IDX_W-1:0]          idx_q, idx_d;
    logic [K_W-1:0]            k_q, k_d;
    logic [ADR_WIDTH-1:0]      wptr_q, wptr_d;

    // Shadow copy of the requester inputs, frozen for the whole build
    logic [NREQ-1:0]           sh_en_q, sh_en_d;
    logic [NREQ*ADR_WIDTH-1:0] sh_adr_q, sh_adr_d;
    logic [NREQ*OUT_WIDTH-1:0] sh_x_q, sh_x_d;
    logic [NREQ*OUT_WIDTH-1:0] sh_y_q, sh_y_d;

    logic [ADR_WIDTH-1:0]      rom_adr_d;
    logic [ADR_WIDTH-1:0]      ram_adr_d;
    logic [DATAWIDTH-1:0]      ram_data_d;
    logic                      ram_we_d;
    logic [ADR_WIDTH-1:0]      frame_len_d;
    logic                      overflow_d;
    logic                      go_d;

    // Point word fields and offset sums (coordinates wrap, no saturation)
    logic [SEL_W-1:0]          sel;
    logic [1:0]                pt_ctrl;
    logic [OUT_WIDTH-1:0]      pt_x, pt_y;
    logic [OUT_WIDTH-1:0]      sum_x, sum_y;
    logic                      sprite_end;
    logic                      ram_full;

    assign sel        = idx_q[SEL_W-1:0];
    assign pt_ctrl    = rom_data[DATAWIDTH-1 -: 2];
    assign pt_x       = rom_data[2*OUT_WIDTH-1 -: OUT_WIDTH];
    assign pt_y       = rom_data[OUT_WIDTH-1:0];
    assign sum_x      = pt_x + sh_x_q[sel*OUT_WIDTH +: OUT_WIDTH];
    assign sum_y      = pt_y + sh_y_q[sel*OUT_WIDTH +: OUT_WIDTH];
    // ctrl 11 and 10 both close a sprite; the runaway guard does too
    assign sprite_end = pt_ctrl[1] || (k_q == K_W'(MAX_SPRITE - 1));
    // Last RAM word is reserved for the terminator
    assign ram_full   = (wptr_q == ADR_WIDTH'(RAM_DEPTH - 1));

    // Next-state and registered-output logic
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        k_d         = k_q;
        wptr_d      = wptr_q;
        sh_en_d     = sh_en_q;
        sh_adr_d    = sh_adr_q;
        sh_x_d      = sh_x_q;
        sh_y_d      = sh_y_q;
        rom_adr_d   = rom_adr;
        ram_adr_d   = ram_adr;
        ram_data_d  = ram_data;
        ram_we_d    = 1'b0;
        frame_len_d = frame_len;
        overflow_d  = overflow;
        go_d        = 1'b0;

        case (state_q)
            SNAP: begin
                sh_en_d    = req_en;
                sh_adr_d   = req_adr;
                sh_x_d     = req_x;
                sh_y_d     = req_y;
                wptr_d     = '0;
                idx_d      = '0;
                overflow_d = 1'b0;
                state_d    = SCAN;
            end

            SCAN: begin
                if (idx_q == IDX_W'(NREQ)) begin
                    // Terminator write is registered so it is on the port during TERM
                    ram_we_d   = 1'b1;
                    ram_adr_d  = wptr_q;
                    ram_data_d = TERM_WORD;
                    state_d    = TERM;
                end else if (sh_en_q[sel]) begin
                    // rom_adr is registered, so the first word is on rom_data in FETCH
                    rom_adr_d = sh_adr_q[sel*ADR_WIDTH +: ADR_WIDTH];
                    k_d       = '0;
                    state_d   = FETCH;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end

            FETCH: begin
                if (sprite_end) begin
                    idx_d   = idx_q + IDX_W'(1);
                    state_d = SCAN;
                end else if (ram_full) begin
                    // Drop the point and abandon the remaining requesters
                    overflow_d = 1'b1;
                    ram_we_d   = 1'b1;
                    ram_adr_d  = wptr_q;
                    ram_data_d = TERM_WORD;
                    state_d    = TERM;
                end else begin
                    ram_we_d   = 1'b1;
                    ram_adr_d  = wptr_q;
                    ram_data_d = DATAWIDTH'({pt_ctrl, sum_x, sum_y});
                    wptr_d     = wptr_q + ADR_WIDTH'(1);
                    k_d        = k_q + K_W'(1);
                    rom_adr_d  = rom_adr + ADR_WIDTH'(1);
                end
            end

            TERM: begin
                frame_len_d = wptr_q + ADR_WIDTH'(1);
                go_d        = 1'b1;
                state_d     = IDLE;
            end

            IDLE: begin
                if (halt) begin
                    state_d = SNAP;
                end else begin
                    go_d = 1'b1;
                end
            end

            default: begin
                state_d = SNAP;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= SNAP;
            idx_q     <= '0;
            k_q       <= '0;
            wptr_q    <= '0;
            sh_en_q   <= '0;
            sh_adr_q  <= '0;
            sh_x_q    <= '0;
            sh_y_q    <= '0;
            rom_adr   <= '0;
            ram_adr   <= '0;
            ram_data  <= '0;
            ram_we    <= 1'b0;
            frame_len <= '0;
            overflow  <= 1'b0;
            go        <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            k_q       <= k_d;
            wptr_q    <= wptr_d;
            sh_en_q   <= sh_en_d;
            sh_adr_q  <= sh_adr_d;
            sh_x_q    <= sh_x_d;
            sh_y_q    <= sh_y_d;
            rom_adr   <= rom_adr_d;
            ram_adr   <= ram_adr_d;
            ram_data  <= ram_data_d;
            ram_we    <= ram_we_d;
            frame_len <= frame_len_d;
            overflow  <= overflow_d;
            go        <= go_d;
        end
    end

endmodule

// File: tb/tb_frame_build_scheduler.sv
// tb_frame_build_scheduler
//   Scoreboard bench: each frame request pushes the expected RAM writes and
//   frame summary computed by a sprite-list walk over the bench's ROM image;
//   a monitor pops and compares whenever the DUT writes RAM or raises go.
`timescale 1ns/1ps
module tb_frame_build_scheduler;

    localparam int unsigned NREQ  = 4;
    localparam int unsigned AW    = 16;
    localparam int unsigned DW    = 18;
    localparam int unsigned OW    = 8;
    localparam int unsigned DEPTH = 24;
    localparam int unsigned MAXS  = 12;
    localparam int          LIMIT = 3000;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 halt;
    logic                 go;
    logic [NREQ-1:0]      req_en;
    logic [NREQ*AW-1:0]   req_adr;
    logic [NREQ*OW-1:0]   req_x;
    logic [NREQ*OW-1:0]   req_y;
    logic [AW-1:0]        rom_adr;
    logic [DW-1:0]        rom_data;
    logic [AW-1:0]        ram_adr;
    logic [DW-1:0]        ram_data;
    logic                 ram_we;
    logic [AW-1:0]        frame_len;
    logic                 overflow;

    logic [DW-1:0] rom     [0:65535];
    logic [DW-1:0] ram_img [0:255];

    typedef struct { logic [AW-1:0] adr; logic [DW-1:0] data; } wr_t;
    typedef struct { int flen; int ovf; } frm_t;
    wr_t  exp_q[$];
    frm_t frm_q[$];

    // Current frame configuration
    logic [NREQ-1:0] c_en;
    logic [AW-1:0]   c_adr [NREQ];
    logic [OW-1:0]   c_x   [NREQ];
    logic [OW-1:0]   c_y   [NREQ];

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    assign rom_data = rom[rom_adr];

    frame_build_scheduler #(
        .NREQ(NREQ), .ADR_WIDTH(AW), .DATAWIDTH(DW), .OUT_WIDTH(OW),
        .RAM_DEPTH(DEPTH), .MAX_SPRITE(MAXS)
    ) dut (
        .clk(clk), .rst(rst), .halt(halt), .go(go),
        .req_en(req_en), .req_adr(req_adr), .req_x(req_x), .req_y(req_y),
        .rom_adr(rom_adr), .rom_data(rom_data),
        .ram_adr(ram_adr), .ram_data(ram_data), .ram_we(ram_we),
        .frame_len(frame_len), .overflow(overflow)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic apply_cfg();
        req_en = c_en;
        for (int i = 0; i < NREQ; i++) begin
            req_adr[i*AW +: AW] = c_adr[i];
            req_x[i*OW +: OW]   = c_x[i];
            req_y[i*OW +: OW]   = c_y[i];
        end
    endtask

    // Walk the enabled sprite lists, push expected writes and frame summary,
    // and return the cycle (counted from SNAP = 0) in which go is first high.
    task automatic model(output int lat);
        int            wp;
        int            cyc;
        int            ovf;
        logic [DW-1:0] w;
        logic [AW-1:0] a;
        wr_t           e;
        frm_t          f;
        wp  = 0;
        ovf = 0;
        cyc = 1;
        for (int i = 0; i < NREQ && ovf == 0; i++) begin
            cyc++;
            if (c_en[i]) begin
                for (int k = 0; k < MAXS; k++) begin
                    cyc++;
                    a = c_adr[i] + AW'(k);
                    w = rom[a];
                    if (w[DW-1] || k == MAXS - 1) break;
                    if (wp == DEPTH - 1) begin
                        ovf = 1;
                        break;
                    end
                    e.adr  = AW'(wp);
                    e.data = {w[17:16],
                              8'((int'(w[15:8]) + int'(c_x[i])) % 256),
                              8'((int'(w[7:0])  + int'(c_y[i])) % 256)};
                    exp_q.push_back(e);
                    wp++;
                end
            end
        end
        if (ovf == 0) cyc++;
        e.adr  = AW'(wp);
        e.data = 18'h20000;
        exp_q.push_back(e);
        cyc++;
        f.flen = wp + 1;
        f.ovf  = ovf;
        frm_q.push_back(f);
        lat = cyc;
    endtask

    // Called at a negedge inside the SNAP cycle; returns cycles until go.
    task automatic wait_go(input bit scramble, output int n);
        n = 0;
        while (!go && n < LIMIT) begin
            @(negedge clk);
            halt = 1'b0;
            n++;
            if (n == 1) chk("ovf_clear", overflow, 0);
            if (scramble && !go && $urandom_range(0, 3) == 0) begin
                req_en  = 4'($urandom());
                req_adr = {$urandom(), $urandom()};
                req_x   = $urandom();
                req_y   = $urandom();
                halt    = 1'($urandom_range(0, 1));
            end
        end
        if (!go) chk("go_timeout", go, 1);
    endtask

    task automatic run_frame(input bit scramble, input int idle);
        int lat;
        int n;
        repeat (idle) begin
            @(negedge clk);
            chk("go_hold", go, 1);
        end
        #1;
        apply_cfg();
        model(lat);
        halt = 1'b1;
        @(posedge clk);
        @(negedge clk);
        halt = 1'b0;
        chk("go_drop", go, 0);
        wait_go(scramble, n);
        chk("latency", n, lat);
    endtask

    task automatic check_reset_outs();
        chk("rst_ctl", {go, ram_we, overflow}, 0);
        chk("rst_ram", {ram_adr, ram_data}, 0);
        chk("rst_adr", {rom_adr, frame_len}, 0);
    endtask

    // Monitor: compare every RAM write and every go rising edge
    initial begin
        wr_t  e;
        frm_t f;
        logic go_q;
        go_q = 1'b0;
        forever begin
            @(negedge clk);
            if (ram_we) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_write: adr %0h data %0h, no write expected", ram_adr, ram_data);
                end else begin
                    e = exp_q.pop_front();
                    chk("wr_adr", ram_adr, e.adr);
                    chk("wr_data", ram_data, e.data);
                end
                ram_img[ram_adr[7:0]] = ram_data;
            end
            if (go && !go_q) begin
                if (frm_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_go: frame_len %0d, no frame expected", frame_len);
                end else begin
                    f = frm_q.pop_front();
                    chk("frame_len", frame_len, f.flen);
                    chk("overflow", overflow, f.ovf);
                    chk("writes_done", exp_q.size(), 0);
                end
            end
            go_q = go;
        end
    end

    initial begin
        int lat;
        int n;
        logic [AW-1:0] b;
        int len;

        rst    = 1'b1;
        halt   = 1'b0;
        req_en = '0;
        req_adr = '0;
        req_x  = '0;
        req_y  = '0;
        for (int a = 0; a < 65536; a++) rom[a] = 18'h30000;
        for (int a = 0; a < 256; a++) ram_img[a] = '0;

        // Directed sprites
        rom[16'h0010] = 18'h10505;
        rom[16'h0011] = 18'h00805;
        rom[16'h0012] = 18'h00808;
        rom[16'h0013] = 18'h30000;
        rom[16'h0020] = 18'h00A05;
        rom[16'h0021] = 18'h30000;
        for (int s = 0; s < 3; s++) begin
            b = AW'(16'h0040 + s * 32);
            for (int p = 0; p < 10; p++) rom[b + AW'(p)] = {2'b00, 16'($urandom())};
            rom[b + AW'(10)] = 18'h30000;
        end
        // Random sprites, some longer than the runaway guard, ends coded 11 or 10
        for (int s = 0; s < 8; s++) begin
            b   = AW'(16'h0100 + s * 32);
            len = $urandom_range(0, 14);
            for (int p = 0; p < len; p++) rom[b + AW'(p)] = {1'b0, 1'($urandom()), 16'($urandom())};
            rom[b + AW'(len)] = {1'b1, 1'($urandom()), 16'($urandom())};
        end

        // Test 1: reset, single sprite with offset (10,20)
        c_en = 4'b0001;
        for (int i = 0; i < NREQ; i++) begin
            c_adr[i] = 16'h0010;
            c_x[i]   = 8'd10;
            c_y[i]   = 8'd20;
        end
        apply_cfg();
        #2 rst = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outs();
        model(lat);
        rst = 1'b1;
        wait_go(1'b0, n);
        chk("latency", n, lat);
        chk("t1_ram0", ram_img[0], 18'h10F19);
        chk("t1_ram1", ram_img[1], 18'h01219);
        chk("t1_ram2", ram_img[2], 18'h0121C);
        chk("t1_ram3", ram_img[3], 18'h20000);
        chk("t1_len", frame_len, 4);

        // Test 2: x wraps (10 + 250 = 4); halt in the cycle go rises
        c_adr[0] = 16'h0020;
        c_x[0]   = 8'd250;
        c_y[0]   = 8'd0;
        run_frame(1'b0, 0);
        chk("t2_ram0", ram_img[0], 18'h00405);
        chk("t2_ovf", overflow, 0);

        // Test 3: nothing enabled, terminator only; halts/input changes during build
        c_en = 4'b0000;
        run_frame(1'b1, 1);
        chk("t3_ram0", ram_img[0], 18'h20000);
        chk("t3_len", frame_len, 1);

        // Test 4: three 10-point sprites overflow a 24-word RAM
        c_en = 4'b0111;
        for (int i = 0; i < 3; i++) begin
            c_adr[i] = AW'(16'h0040 + i * 32);
            c_x[i]   = 8'($urandom());
            c_y[i]   = 8'($urandom());
        end
        run_frame(1'b1, 2);
        chk("t4_ovf", overflow, 1);
        chk("t4_len", frame_len, DEPTH);
        chk("t4_term", ram_img[DEPTH-1], 18'h20000);
        @(negedge clk);
        chk("t4_ovf_sticky", overflow, 1);

        // Random frames with mid-build input changes and ignored halts
        for (int f = 0; f < 30; f++) begin
            c_en = 4'($urandom());
            for (int i = 0; i < NREQ; i++) begin
                c_adr[i] = AW'(16'h0100 + $urandom_range(0, 7) * 32);
                c_x[i]   = 8'($urandom());
                c_y[i]   = 8'($urandom());
            end
            run_frame(1'b1, $urandom_range(0, 2));
        end

        // Test 6: reset during FETCH, build restarts from RAM[0]
        c_en = 4'b0001;
        for (int i = 0; i < NREQ; i++) begin
            c_adr[i] = 16'h0010;
            c_x[i]   = 8'd10;
            c_y[i]   = 8'd20;
        end
        @(negedge clk);
        #1;
        apply_cfg();
        model(lat);
        halt = 1'b1;
        @(posedge clk);
        @(negedge clk);
        halt = 1'b0;
        repeat (3) @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check_reset_outs();
        exp_q.delete();
        frm_q.delete();
        @(negedge clk);
        model(lat);
        rst = 1'b1;
        wait_go(1'b0, n);
        chk("latency", n, lat);
        chk("t6_ram0", ram_img[0], 18'h10F19);

        repeat (3) @(negedge clk);
        chk("leftover_writes", exp_q.size(), 0);
        chk("leftover_frames", frm_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
